// File: rtl/scalable_core.sv
// Multi-cycle ADD/LD/ST/BEQ core. Register file and data memory are internal. Build option: ZERO_REG_EN hard-wires register 0 to zero.
// Latency: retired pulses 1 cycle after accept for ADD/ST/BEQ and 2 cycles after accept for LD.
// Backpressure: instr_req stays high in FETCH, and the core stalls there for as long as instr_valid is low.
module scalable_core #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 2,
  parameter int DMEM_AW = 5,
  parameter int PC_W    = 8,
  localparam int INSTR_W = 2 + 3*REG_AW
) (
  input  logic               clock,
  input  logic               reset,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [DATA_W-1:0]  display_data,
  output logic               reg_we,
  output logic               retired
);
  localparam int NREG  = 1 << REG_AW;
  localparam int DEPTH = 1 << DMEM_AW;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  ld_q;
  logic [DATA_W-1:0]  disp_q;
  logic               reg_we_q, retired_q;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [DATA_W-1:0]  mem_q  [DEPTH];

  logic [1:0]         op;
  logic [REG_AW-1:0]  rs, rt, f;
  logic [DATA_W-1:0]  rs_val, rt_val, imm;
  logic [PC_W-1:0]    imm_pc;
  logic [DMEM_AW-1:0] maddr;
  logic               wr_vld, wr_keep;
  logic [REG_AW-1:0]  wr_idx;
  logic [DATA_W-1:0]  wr_dat;

  assign op     = ir_q[INSTR_W-1 -: 2];
  assign rs     = ir_q[3*REG_AW-1 -: REG_AW];
  assign rt     = ir_q[2*REG_AW-1 -: REG_AW];
  assign f      = ir_q[REG_AW-1:0];
  assign imm    = {{(DATA_W-REG_AW){f[REG_AW-1]}}, f};
  assign imm_pc = {{(PC_W-REG_AW){f[REG_AW-1]}}, f};

  always_comb begin
    rs_val = regs_q[rs];
    rt_val = regs_q[rt];
`ifdef ZERO_REG_EN
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
`endif
    maddr = DMEM_AW'(rs_val + imm);
  end

  // A single write port serves ADD in EXEC and the LD writeback in MEM.
  always_comb begin
    wr_vld = 1'b0;
    wr_idx = f;
    wr_dat = rs_val + rt_val;
    pc_d   = pc_q + PC_W'(1);
    if (state_q == EXEC && op == OP_ADD) begin
      wr_vld = 1'b1;
    end else if (state_q == MEM) begin
      wr_vld = 1'b1;
      wr_idx = rt;
      wr_dat = ld_q;
    end
    if (state_q == EXEC && op == OP_BEQ && rs_val == rt_val)
      pc_d = pc_q + PC_W'(1) + imm_pc;
`ifdef ZERO_REG_EN
    wr_keep = (wr_idx != '0);
`else
    wr_keep = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      ld_q      <= '0;
      disp_q    <= '0;
      reg_we_q  <= 1'b0;
      retired_q <= 1'b0;
      for (int i = 0; i < NREG; i++)  regs_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i]  <= DATA_W'(i);
    end else begin
      reg_we_q  <= 1'b0;
      retired_q <= 1'b0;
      if (wr_vld) begin
        disp_q   <= wr_dat;
        reg_we_q <= 1'b1;
        if (wr_keep) regs_q[wr_idx] <= wr_dat;
      end
      case (state_q)
        FETCH: if (instr_valid) begin
          ir_q    <= instr_data;
          state_q <= EXEC;
        end
        EXEC: begin
          if (op == OP_LD) begin
            ld_q    <= mem_q[maddr];
            state_q <= MEM;
          end else begin
            if (op == OP_ST) mem_q[maddr] <= rt_val;
            pc_q      <= pc_d;
            retired_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        MEM: begin
          pc_q      <= pc_d;
          retired_q <= 1'b1;
          state_q   <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign instr_req    = (state_q == FETCH);
  assign instr_addr   = pc_q;
  assign display_data = disp_q;
  assign reg_we       = reg_we_q;
  assign retired      = retired_q;
endmodule

// File: doc/scalable_core.md
Name: scalable_core

Overview:
- Parametrised multi-cycle successor to the team's single-cycle 8-bit processor: configurable data width, register count and data-memory depth.
- Fetches instructions over a req/valid handshake instead of a free-running instruction bus, so it can stall.
- Register file and data memory are internal. The last register-write value is exported for the seven-segment console drivers.

Parameters:
- DATA_W, 8, datapath and register width.
- REG_AW, 2, register index width; register count = 2^REG_AW.
- DMEM_AW, 5, data-memory address width; depth = 2^DMEM_AW.
- PC_W, 8, program counter width.
- Derived, not overridable: INSTR_W = 2 + 3*REG_AW.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
- instr_req  out  1  high while the core waits for an instruction.
- instr_addr  out  PC_W  current PC, valid while instr_req = 1.
- instr_valid  in  1  instr_data is valid this cycle.
- instr_data  in  INSTR_W  instruction word.
- display_data  out  DATA_W  last value written to any register.
- reg_we  out  1  one-cycle pulse on every register write.
- retired  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Instruction format, MSB to LSB: op[2] | rs[REG_AW] | rt[REG_AW] | f[REG_AW].
  - imm = f sign-extended to DATA_W (and to PC_W for branches).
- Opcodes:
  - 00 ADD: R[f] = R[rs] + R[rt].
  - 01 LD: R[rt] = M[R[rs] + imm].
  - 10 ST: M[R[rs] + imm] = R[rt].
  - 11 BEQ: if R[rs] == R[rt], PC = PC + 1 + imm; otherwise PC + 1.
- Arithmetic: all sums truncate modulo 2^DATA_W (or 2^PC_W for the PC). Memory address = low DMEM_AW bits of the sum, so addresses wrap.
- FSM states FETCH, EXEC, MEM:
  - FETCH: instr_req = 1. When instr_valid = 1, latch instr_data into IR and go to EXEC. instr_valid in the same cycle instr_req rises is accepted. With instr_valid = 0 the core stays in FETCH with no state change (unbounded stall).
  - EXEC, ADD: write register, pulse reg_we and retired, PC += 1, go to FETCH.
  - EXEC, ST: write memory, pulse retired, PC += 1, go to FETCH.
  - EXEC, BEQ: update PC, pulse retired, go to FETCH.
  - EXEC, LD: register the memory read data, go to MEM.
  - MEM: write R[rt], pulse reg_we and retired, PC += 1, go to FETCH.
- Latency from accept cycle to retired: ADD/ST/BEQ = 1 cycle, LD = 2 cycles. Minimum issue interval: 2 cycles (ADD/ST/BEQ), 3 cycles (LD).
- instr_valid is ignored outside FETCH.
- display_data updates in the same edge as each register write.
- Reset (reset = 0 at a clock edge), from any state including mid-LD:
  - state = FETCH, PC = 0, all registers = 0, display_data = 0.
  - reg_we = 0, retired = 0, instr_req = 1 in the first cycle after reset releases.
  - M[i] = i truncated to DATA_W for every i.
  - Any in-flight write is discarded.
- instr_addr always equals PC; PC wraps from 2^PC_W - 1 to 0.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined: register 0 reads as 0 at all times. Writes targeting register 0 are discarded, but reg_we and retired still pulse and display_data shows the discarded value.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Defaults in all scenarios. 8-bit encoding = op | rs | rt | f, 2 bits each.
- Load: reset, then instr 0x45 (LD r1 = M[r0+1]) with instr_valid held high → retired 2 cycles after accept; r1 = 0x01; display_data = 0x01; PC = 1; reg_we pulses once.
- Store/reload: with r1 = 1, issue 0x16 (r2 = r1 + r1 = 2), then 0xAB (ST M[r2-1] = r2), then 0x4D (LD r3 = M[r0+1]) → r3 = 0x02; display_data = 0x02; PC = 4.
- Branch: BEQ 0xC2 (r0 == r0, imm = -2) fetched at PC 5 → next instr_addr = 4. BEQ 0xC4 with r0 = 0, r1 = 1 → next instr_addr = 6.
- Wrap: r1 = 1, then ADD 0x15 (r1 = r1 + r1) issued 8 times → display_data sequence 02, 04, 08, 10, 20, 40, 80, 00.
- Stall and reset: hold instr_valid = 0 for 5 cycles → instr_req stays 1, PC and registers unchanged, no pulses. Then assert reset = 0 during the MEM state of an LD → next cycle state is FETCH, PC = 0, target register still 0, M[1] = 1.
- ZERO_REG_EN defined: LD 0x41 (r0 = M[r0+1]) then ADD 0x02 (r2 = r0 + r0) → r2 = 0x00. With the macro undefined → r2 = 0x02.
